mem_wait_bridge: RTL and testbench

Sits between the picorv32 native memory port (`mem_valid`/`mem_ready`) and a single-cycle synchronous word RAM. Each core request is held for a programmable or pseudo-random number of wait cycles, then served with one RAM access. Fuzzing runs use it to vary memory latency. It also flags out-of-range addresses and keeps transaction and stall counters for coverage.

---
 rtl/mem_wait_bridge.sv | 217 +++++++++++++++++++++
 tb/tb_mem_wait_bridge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_bridge.sv
// mem_wait_bridge: holds each picorv32 native-port request for a programmed
// or LFSR-derived number of wait cycles, then serves it with one access to a
// single-cycle synchronous word RAM. Flags out-of-range word addresses and
// keeps transaction / stall counters.
module mem_wait_bridge #(
    parameter int          MEM_WORDS = 16384,
    parameter int          WAIT_W    = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int         AW        = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [1:0]        wait_mode,
    input  logic [WAIT_W-1:0] wait_fixed,
    input  logic              seed_load,
    input  logic [15:0]       seed_value,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              ram_en,
    output logic [AW-1:0]     ram_addr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_wstrb,
    input  logic [31:0]       ram_rdata,
    output logic              bus_err,
    output logic [31:0]       err_addr,
    output logic [31:0]       txn_count,
    output logic [31:0]       stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // One step of the 16-bit Galois LFSR used for random wait counts.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    state_t              state_r, next_s;
    logic [WAIT_W-1:0]   cnt_r;
    logic [31:0]         addr_r, wdata_r;
    logic [3:0]          wstrb_r;
    logic                instr_r;
    logic [15:0]         lfsr_r;
    logic                ram_en_r, acc_rd_r, ready_r, rd_sel_r, bus_err_r;
    logic [AW-1:0]       ram_addr_r;
    logic [31:0]         ram_wdata_r, err_addr_r, txn_r, stall_r;
    logic [3:0]          ram_wstrb_r;

    logic                accept_s, enter_acc_s, in_range_s;
    logic [WAIT_W-1:0]   wait_n_s;
    logic [31:0]         src_addr_s, src_wdata_s;
    logic [3:0]          src_wstrb_s;

    // Request acceptance, wait-count selection and the address range check.
    // The ACCESS-cycle RAM strobes are registered on the edge entering
    // ACCESS, so the request fields come straight from the port when
    // ACCESS follows IDLE directly, and from the latched copy after WAIT.
    always_comb begin
        accept_s = (state_r == ST_IDLE) && mem_valid;
        case (wait_mode)
            2'd1:    wait_n_s = wait_fixed;
            2'd2:    wait_n_s = lfsr_r[WAIT_W-1:0];
            default: wait_n_s = {WAIT_W{1'b0}};
        endcase
        if (state_r == ST_IDLE) begin
            src_addr_s  = mem_addr;
            src_wdata_s = mem_wdata;
            src_wstrb_s = mem_wstrb;
        end else begin
            src_addr_s  = addr_r;
            src_wdata_s = wdata_r;
            src_wstrb_s = wstrb_r;
        end
        in_range_s  = ({2'b00, src_addr_s[31:2]} < 32'(MEM_WORDS));
        enter_acc_s = (next_s == ST_ACCESS);
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_valid) begin
                    next_s = (wait_n_s != {WAIT_W{1'b0}}) ? ST_WAIT : ST_ACCESS;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == WAIT_W'(1)) begin
                    next_s = ST_ACCESS;
                end else begin
                    next_s = ST_WAIT;
                end
            end
            ST_ACCESS: next_s = ST_RESP;
            ST_RESP:   next_s = ST_IDLE;
            default:   next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Latch request fields at acceptance and run the wait down-counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            wstrb_r <= 4'd0;
            instr_r <= 1'b0;
            cnt_r   <= {WAIT_W{1'b0}};
        end else if (accept_s) begin
            addr_r  <= mem_addr;
            wdata_r <= mem_wdata;
            wstrb_r <= mem_wstrb;
            instr_r <= mem_instr;
            cnt_r   <= wait_n_s;
        end else if (state_r == ST_WAIT) begin
            cnt_r   <= cnt_r - WAIT_W'(1);
        end
    end

    // LFSR: a seed load wins over the per-request advance; a request
    // accepted in the same cycle has already sampled the old value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_r <= LFSR_SEED;
        end else if (seed_load) begin
            lfsr_r <= (seed_value == 16'h0000) ? LFSR_SEED : seed_value;
        end else if (accept_s) begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // RAM strobes: high only for the ACCESS cycle of an in-range request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram_en_r    <= 1'b0;
            acc_rd_r    <= 1'b0;
            ram_addr_r  <= {AW{1'b0}};
            ram_wdata_r <= 32'd0;
            ram_wstrb_r <= 4'd0;
        end else begin
            ram_en_r <= enter_acc_s && in_range_s;
            if (enter_acc_s) begin
                acc_rd_r <= in_range_s && (src_wstrb_s == 4'd0);
            end
            if (enter_acc_s && in_range_s) begin
                ram_addr_r  <= src_addr_s[AW+1:2];
                ram_wdata_r <= src_wdata_s;
                ram_wstrb_r <= src_wstrb_s;
            end
        end
    end

    // Sticky out-of-range flag; only the first offending address is kept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus_err_r  <= 1'b0;
            err_addr_r <= 32'd0;
        end else if (enter_acc_s && !in_range_s) begin
            bus_err_r <= 1'b1;
            if (!bus_err_r) begin
                err_addr_r <= src_addr_s;
            end
        end
    end

    // Completion pulse, read-data select and the coverage counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_r  <= 1'b0;
            rd_sel_r <= 1'b0;
            txn_r    <= 32'd0;
            stall_r  <= 32'd0;
        end else begin
            ready_r  <= (next_s == ST_RESP);
            rd_sel_r <= (next_s == ST_RESP) && acc_rd_r;
            if (next_s == ST_RESP) begin
                txn_r <= txn_r + 32'd1;
            end
            if ((state_r == ST_WAIT) && (stall_r != 32'hFFFF_FFFF)) begin
                stall_r <= stall_r + 32'd1;
            end
        end
    end

    // RAM data only arrives during RESP, so the read path is a gated mux
    // controlled by a registered select rather than a data register.
    assign mem_rdata    = rd_sel_r ? ram_rdata : 32'd0;
    assign mem_ready    = ready_r;
    assign ram_en       = ram_en_r;
    assign ram_addr     = ram_addr_r;
    assign ram_wdata    = ram_wdata_r;
    assign ram_wstrb    = ram_wstrb_r;
    assign bus_err      = bus_err_r;
    assign err_addr     = err_addr_r;
    assign txn_count    = txn_r;
    assign stall_cycles = stall_r;

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Scoreboard bench for mem_wait_bridge: expected responses are pushed when a
// request is driven and popped when mem_ready is observed.
module tb_mem_wait_bridge;

    localparam int MW = 16384;
    localparam int WW = 3;

    logic          clk = 1'b0;
    logic          resetn;
    logic [1:0]    wait_mode;
    logic [WW-1:0] wait_fixed;
    logic          seed_load;
    logic [15:0]   seed_value;
    logic          mem_valid, mem_instr;
    logic [31:0]   mem_addr, mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          ram_en;
    logic [13:0]   ram_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_wstrb;
    logic [31:0]   ram_rdata = 32'd0;
    logic          bus_err;
    logic [31:0]   err_addr, txn_count, stall_cycles;

    always #5 clk = ~clk;

    mem_wait_bridge #(.MEM_WORDS(MW), .WAIT_W(WW), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .resetn(resetn), .wait_mode(wait_mode), .wait_fixed(wait_fixed),
        .seed_load(seed_load), .seed_value(seed_value), .mem_valid(mem_valid),
        .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata), .bus_err(bus_err),
        .err_addr(err_addr), .txn_count(txn_count), .stall_cycles(stall_cycles)
    );

    // Synchronous word RAM (256 words, aliased on the low index bits).
    logic [31:0] ram_arr [0:255];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= ram_arr[ram_addr[7:0]];
            for (int b = 0; b < 4; b++) begin
                if (ram_wstrb[b]) ram_arr[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        int          lat;
        int          ens;
        logic [31:0] raddr;
    } exp_t;
    exp_t sb[$];

    // Bench-side reference state.
    logic [31:0] mem_m [0:255];
    logic [15:0] lfsr_m;
    logic [31:0] stall_m, txn_m, err_m;
    logic        err_seen;
    int          errs = 0;
    int          checks = 0;

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        lfsr_m   = 16'hACE1;
        stall_m  = 32'd0;
        txn_m    = 32'd0;
        err_m    = 32'd0;
        err_seen = 1'b0;
        sb.delete();
    endtask

    task automatic do_req(input logic [1:0] mode, input logic [WW-1:0] fixed,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic sload,
                          input logic [15:0] sval);
        int          n, k, ens;
        bit          inr, done;
        logic [7:0]  idx;
        logic [31:0] ea, ew;
        logic [3:0]  es;
        exp_t        e, g;
        case (mode)
            2'd1:    n = int'(fixed);
            2'd2:    n = int'(lfsr_m[WW-1:0]);
            default: n = 0;
        endcase
        if (sload) lfsr_m = (sval == 16'h0000) ? 16'hACE1 : sval;
        else       lfsr_m = lstep(lfsr_m);
        inr = (addr[31:2] < 30'(MW));
        idx = addr[9:2];
        e.rdata = (inr && wstrb == 4'd0) ? mem_m[idx] : 32'd0;
        if (inr) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        e.lat   = 2 + n;
        e.ens   = inr ? 1 : 0;
        e.raddr = {18'd0, addr[15:2]};
        if (!inr && !err_seen) begin
            err_m = addr;
            err_seen = 1'b1;
        end
        stall_m = stall_m + 32'(n);
        txn_m   = txn_m + 32'd1;
        sb.push_back(e);

        wait_mode  = mode;
        wait_fixed = fixed;
        seed_load  = sload;
        seed_value = sval;
        mem_addr   = addr;
        mem_wdata  = wdata;
        mem_wstrb  = wstrb;
        mem_instr  = 1'b0;
        mem_valid  = 1'b1;
        k = 0; ens = 0; done = 0; ea = 32'd0; ew = 32'd0; es = 4'd0;
        while (!done && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
            if (k == 1) begin
                seed_load  = 1'b0;
                wait_mode  = 2'd1;
                wait_fixed = 3'd7;
            end
            if (ram_en) begin
                ens++;
                ea = {18'd0, ram_addr};
                ew = ram_wdata;
                es = ram_wstrb;
                chk("ram_en_cycle", 32'(k), 32'(1 + n));
            end
            if (mem_ready) begin
                done = 1;
                mem_valid = 1'b0;
                chk("rdata", mem_rdata, (sb.size() > 0) ? sb[0].rdata : 32'hDEAD_0000);
            end
        end
        mem_valid = 1'b0;
        g = sb.pop_front();
        chk("latency", 32'(k), 32'(g.lat));
        chk("ram_en_count", 32'(ens), 32'(g.ens));
        if (g.ens == 1) begin
            chk("ram_addr", ea, g.raddr);
            chk("ram_wstrb", {28'd0, es}, {28'd0, wstrb});
            if (wstrb != 4'd0) chk("ram_wdata", ew, wdata);
        end
        @(posedge clk);
        @(negedge clk);
        chk("ready_pulse", {31'd0, mem_ready}, 32'd0);
        chk("rdata_idle", mem_rdata, 32'd0);
        chk("txn_count", txn_count, txn_m);
        chk("stall_cycles", stall_cycles, stall_m);
        chk("bus_err", {31'd0, bus_err}, {31'd0, err_seen});
        chk("err_addr", err_addr, err_m);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"}, {31'd0, mem_ready}, 32'd0);
        chk({tag, "_ram_en"}, {31'd0, ram_en}, 32'd0);
        chk({tag, "_bus_err"}, {31'd0, bus_err}, 32'd0);
        chk({tag, "_rdata"}, mem_rdata, 32'd0);
        chk({tag, "_ram_addr"}, {18'd0, ram_addr}, 32'd0);
        chk({tag, "_ram_wdata"}, ram_wdata, 32'd0);
        chk({tag, "_ram_wstrb"}, {28'd0, ram_wstrb}, 32'd0);
        chk({tag, "_err_addr"}, err_addr, 32'd0);
        chk({tag, "_txn"}, txn_count, 32'd0);
        chk({tag, "_stall"}, stall_cycles, 32'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [3:0]  rs;
        for (int i = 0; i < 256; i++) begin
            ram_arr[i] = 32'h1000_0000 + 32'(i);
            mem_m[i]   = 32'h1000_0000 + 32'(i);
        end
        ram_arr[4] = 32'h0000_0013;
        mem_m[4]   = 32'h0000_0013;
        resetn = 1'b0; wait_mode = 2'd0; wait_fixed = 3'd0; seed_load = 1'b0;
        seed_value = 16'h0000; mem_valid = 1'b0; mem_instr = 1'b0;
        mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        resetn = 1'b1;
        @(negedge clk);

        // Random waits from the reset seed: 1 then 0.
        do_req(2'd2, 3'd0, 32'h0000_0010, 32'd0, 4'd0, 1'b0, 16'h0000);
        do_req(2'd2, 3'd0, 32'h0000_0014, 32'd0, 4'd0, 1'b0, 16'h0000);
        // No wait, fixed wait write, mode 3 readback.
        do_req(2'd0, 3'd0, 32'h0000_0010, 32'd0, 4'd0, 1'b0, 16'h0000);
        do_req(2'd1, 3'd5, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 1'b0, 16'h0000);
        do_req(2'd3, 3'd4, 32'h0000_0020, 32'd0, 4'd0, 1'b0, 16'h0000);
        // Partial write, then read back with maximum fixed wait.
        do_req(2'd1, 3'd2, 32'h0000_0024, 32'hA5A5_5A5A, 4'b0101, 1'b0, 16'h0000);
        do_req(2'd1, 3'd7, 32'h0000_0024, 32'd0, 4'd0, 1'b0, 16'h0000);
        // Seed load alongside a request, zero seed and a non-zero seed.
        do_req(2'd2, 3'd0, 32'h0000_0030, 32'd0, 4'd0, 1'b1, 16'h0000);
        do_req(2'd2, 3'd0, 32'h0000_0034, 32'd0, 4'd0, 1'b0, 16'h0000);
        do_req(2'd0, 3'd0, 32'h0000_0038, 32'd0, 4'd0, 1'b1, 16'h1237);
        do_req(2'd2, 3'd0, 32'h0000_003C, 32'd0, 4'd0, 1'b0, 16'h0000);
        // Out-of-range accesses and the last valid word.
        do_req(2'd0, 3'd0, 32'h0001_0000, 32'd0, 4'd0, 1'b0, 16'h0000);
        do_req(2'd1, 3'd1, 32'h0002_0000, 32'h1111_2222, 4'hF, 1'b0, 16'h0000);
        do_req(2'd0, 3'd0, 32'h0000_FFFC, 32'd0, 4'd0, 1'b0, 16'h0000);
        // Mixed random traffic.
        for (int i = 0; i < 8; i++) begin
            ra = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
            rs = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            do_req(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), ra,
                   $urandom, rs, 1'b0, 16'h0000);
        end

        // Reset in the middle of a WAIT phase.
        wait_mode = 2'd1; wait_fixed = 3'd5; mem_addr = 32'h0000_0040;
        mem_wstrb = 4'd0; mem_valid = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        mem_valid = 1'b0;
        #1;
        check_reset_values("midrst");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_ram_en_hold", {31'd0, ram_en}, 32'd0);
            chk("midrst_ready_hold", {31'd0, mem_ready}, 32'd0);
        end
        resetn = 1'b1;
        model_reset();
        @(negedge clk);
        do_req(2'd0, 3'd0, 32'h0000_0010, 32'd0, 4'd0, 1'b0, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
